// File: rtl/ripple_carry_sequencer.sv
// Time-multiplexes one external 4-bit ripple-carry adder over WIDTH-bit operands,
// one nibble per cycle LSB first, between a request and a result valid/ready port.
module ripple_carry_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic             req_cin_i,
    input  logic             req_sub_i,
    output logic [3:0]       add_a_o,
    output logic [3:0]       add_b_o,
    output logic             add_cin_o,
    input  logic [3:0]       add_s_i,
    input  logic             add_cout_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_sum_o,
    output logic             res_cout_o,
    output logic             res_ovf_o,
    output logic             busy_o
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W+1:0]   nib_lsb;

    assign nib_lsb = {cnt_q, 2'b00};

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = RUN;
                    a_d     = req_a_i;
                    b_d     = req_b_i ^ {WIDTH{req_sub_i}};
                    carry_d = req_sub_i ? 1'b1 : req_cin_i;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sum_d[nib_lsb +: 4] = add_s_i;
                carry_d             = add_cout_i;
                cnt_d               = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_NIB) begin
                    state_d = DONE;
                    cout_d  = add_cout_i;
                    // Overflow judged against the effective (already inverted) B sign
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s_i[3] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags and adder drive decoded from state
    always_comb begin
        req_ready_o = 1'b0;
        res_valid_o = 1'b0;
        busy_o      = 1'b0;
        add_a_o     = 4'h0;
        add_b_o     = 4'h0;
        add_cin_o   = 1'b0;
        case (state_q)
            IDLE: req_ready_o = 1'b1;
            RUN: begin
                busy_o    = 1'b1;
                add_a_o   = a_q[nib_lsb +: 4];
                add_b_o   = b_q[nib_lsb +: 4];
                add_cin_o = carry_q;
            end
            DONE: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign res_sum_o  = sum_q;
    assign res_cout_o = cout_q;
    assign res_ovf_o  = ovf_q;

endmodule

// File: tb/tb_ripple_carry_sequencer.sv
// Directed and random add/sub operations against an arithmetic reference,
// with the nibble stream on the adder port checked every RUN cycle.
module tb_ripple_carry_sequencer;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic             req_cin = 1'b0;
    logic             req_sub = 1'b0;
    logic [3:0]       add_a, add_b, add_s;
    logic             add_cin, add_cout;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout, res_ovf, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_accept = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External 4-bit adder
    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    ripple_carry_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin), .req_sub_i(req_sub),
        .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
        .add_s_i(add_s), .add_cout_i(add_cout),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_sum_o(res_sum), .res_cout_o(res_cout), .res_ovf_o(res_ovf),
        .busy_o(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required=<50000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full operation: present, run four nibbles, hold in DONE for 'hold' cycles, hand off.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input int hold, input bit pulse, input bit keep);
        int full, sfull, beff, c0, mask, e_sum, e_cout, e_ovf;
        beff  = sub ? int'(~b) : int'(b);
        c0    = sub ? 1 : int'(cin);
        full  = sub ? int'(a) - int'(b) : int'(a) + int'(b) + int'(cin);
        sfull = sub ? int'($signed(a)) - int'($signed(b))
                    : int'($signed(a)) + int'($signed(b)) + int'(cin);
        e_sum  = full & 32'hFFFF;
        e_cout = sub ? int'(a >= b) : int'(full > 65535);
        e_ovf  = int'(sfull > 32767 || sfull < -32768);

        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        if (keep && last_accept >= 0) check("issue_interval", 32'(cyc - last_accept), 32'd6);
        last_accept = cyc;
        step();
        if (!keep) req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mask = (1 << (4 * k)) - 1;
            check("add_a", 32'(add_a), 32'((a >> (4 * k)) & 4'hF));
            check("add_b", 32'(add_b), 32'((beff >> (4 * k)) & 15));
            check("add_cin", 32'(add_cin),
                  (k == 0) ? 32'(c0) : 32'((((int'(a) & mask) + (beff & mask) + c0) >> (4 * k)) & 1));
            check("run_flags", {29'd0, busy, req_ready, res_valid}, 32'b100);
            if (pulse && k == 1) begin
                req_valid = 1'b1;
                req_a = ~a;
            end
            if (pulse && k == 2) req_valid = 1'b0;
            step();
        end
        for (int h = 0; h <= hold; h++) begin
            check("res_valid", 32'(res_valid), 32'd1);
            check("req_ready_done", 32'(req_ready), 32'd0);
            check("res_sum", 32'(res_sum), 32'(e_sum));
            check("res_cout", 32'(res_cout), 32'(e_cout));
            check("res_ovf", 32'(res_ovf), 32'(e_ovf));
            if (h == hold) res_ready = 1'b1;
            step();
        end
        check("res_valid_after_hs", 32'(res_valid), 32'd0);
        check("busy_after_hs", 32'(busy), 32'd0);
        if (!keep) res_ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_flags", {29'd0, busy, res_valid, res_cout}, 32'd0);
        check("rst_sum", 32'(res_sum), 32'd0);
        check("rst_ovf", 32'(res_ovf), 32'd0);
        check("rst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        do_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Backpressure in DONE plus a stray request during RUN
        do_op(16'hABCD, 16'h1357, 1'b1, 1'b0, 3, 1'b1, 1'b0);
        repeat (2) begin
            step();
            check("stray_req_ignored", 32'(busy), 32'd0);
        end

        // Reset during the second RUN cycle
        req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0; req_sub = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("pre_rst_run", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_flags", {29'd0, busy, res_valid, res_cout}, 32'd0);
        check("abort_sum", 32'(res_sum), 32'd0);
        check("abort_ovf", 32'(res_ovf), 32'd0);
        check("abort_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_result", 32'(res_valid), 32'd0);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Random operations with random DONE backpressure
        for (int i = 0; i < 12; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        // Back-to-back with valid and ready held high
        res_ready = 1'b1;
        last_accept = -1;
        for (int i = 0; i < 8; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 1'b0, 1'b1);
        end
        req_valid = 1'b0;
        res_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
